fp16_divider: RTL and testbench
===============================

# fp16_divider

Iterative IEEE-754 half-precision divider: computes Q = A / B with a start/done handshake, one quotient bit per clock. It is the inverse-direction companion to the FP16 multiplier array in the MAC datapath and uses the same 16-bit operand format (1 sign, 5 exponent, 10 fraction, bias 15). Results feed normalisation and reciprocal-scaling paths in front of the accumulator.

## Interface
Parameters:
- none. Format constants come from `fp16_pkg`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  16  dividend, captured on the accepting edge.
- `B`  in  16  divisor, captured on the accepting edge.
- `Q`  out  16  quotient; holds the last result until the next `done`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `Q` is valid in that cycle.
- `div_by_zero`  out  1  updated with `done`: high when finite nonzero A is divided by zero B.

## Operation
- Reset (`rst`=0 at an edge): state IDLE; `Q`=16'h0000, `busy`=0, `done`=0, `div_by_zero`=0. A reset mid-operation aborts the operation with no `done`.
- Operand handling: exponent field 0 is treated as zero, so subnormals flush to zero. Exponent field 31 is Inf when the fraction is 0 and NaN otherwise.
- Sign: always A[15]^B[15], except NaN results.
- States: IDLE, UNPACK, DIVIDE, ROUND.
  - IDLE: `start`=1 captures A and B and moves to UNPACK.
  - UNPACK: evaluates special cases in priority order:
    1. any NaN, 0/0, or Inf/Inf -> 16'h7E00;
    2. x/0 with x finite nonzero -> ±Inf (16'h7C00|sign), `div_by_zero`=1;
    3. Inf/x -> ±Inf;
    4. 0/x or x/Inf -> ±0.
  - A special case writes `Q` directly and returns to IDLE with `done`.
  - Otherwise UNPACK loads Ma={1,A[9:0]} and Mb={1,B[9:0]} and sets exp = Ea − Eb + 15 (signed, 7-bit). If Ma<Mb, it shifts Ma left 1 and decrements exp. It clears the quotient and counter, then goes to DIVIDE.
  - DIVIDE: restoring division, 13 iterations. Each iteration: if rem ≥ Mb, subtract and shift in 1; else shift in 0. The remainder is then shifted left. The 13 bits are: 1 integer bit, 10 fraction bits, guard, round. After the 13th bit, go to ROUND.
  - ROUND: sticky = (remainder ≠ 0). Round to nearest, ties to even, on the 11-bit significand.
    - Carry out of rounding: shift right 1 and increment exp.
    - exp ≥ 31: ±Inf.
    - exp ≤ 0: ±0 (flush).
    - Otherwise Q = {sign, exp[4:0], frac}.
    - Register `Q`, pulse `done`, return to IDLE.
- `start` while `busy` is ignored, with no queueing.
- `div_by_zero` is cleared on every non-x/0 completion.

## Timing
- Edge numbering: accepting edge = edge 0.
- Normal path: UNPACK at edge 1, DIVIDE edges 2–14 (13 bits), ROUND at edge 15. `done`=1 and `busy`=0 in the cycle after edge 15, i.e. 16 cycles of latency.
- Special path: `done` in the cycle after edge 1, i.e. 2 cycles of latency.
- `busy`=1 from the cycle after edge 0 up to and excluding the `done` cycle.
- Back-to-back: `start` high during the `done` cycle is accepted, because the state is IDLE. Maximum throughput is one division per 16 cycles.
- `done` is never high for two consecutive cycles.

## Structure
- `fp16_pkg`:
  - constants: BIAS=15, EXP_W=5, FRAC_W=10, QNAN=16'h7E00, PINF=16'h7C00;
  - state enum (IDLE/UNPACK/DIVIDE/ROUND);
  - classify function (zero/inf/nan).
- Sub-module `fp16_round_rne`: combinational rounding.
  - Inputs: sign, signed exp, 13-bit quotient, sticky.
  - Outputs: packed 16-bit result with Inf/zero saturation.
  - Shared with future adder and multiplier clean-up.
- Top level holds the FSM, 4-bit iteration counter, 12-bit remainder, and 13-bit quotient registers.

## Test plan
- 3.0/1.5: A=16'h4200, B=16'h3E00 -> Q=16'h4000, `done` 16 cycles after start, `div_by_zero`=0.
- 1.0/3.0: A=16'h3C00, B=16'h4200 -> Q=16'h3555 (rounding path exercised); −6.0/2.0: 16'hC600/16'h4000 -> 16'hC200.
- 1.0/0: 16'h3C00/16'h0000 -> Q=16'h7C00, `div_by_zero`=1, `done` 2 cycles after start; 0/0 -> 16'h7E00, `div_by_zero`=0.
- Overflow/underflow:
  - 65504/0.5 (16'h7BFF/16'h3800) -> 16'h7C00;
  - 2^-14/2.0 (16'h0400/16'h4000) -> 16'h0000.
- Handshake: `start` pulsed at cycles 3 and 8 mid-operation -> ignored, with exactly one `done`; `start` held high through `done` -> a second operation starts and `done` pulses again 16 cycles later.
- Reset: `rst`=0 at DIVIDE edge 7 -> next cycle `busy`=0, `done`=0, `Q`=0; no `done` afterwards until a new `start`.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 format constants, divider state encoding and operand classification.
package fp16_pkg;

    localparam int unsigned BIAS   = 15;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;

    typedef enum logic [1:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        ROUND
    } state_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    // Exponent field 0 counts as zero, so subnormals flush.
    function automatic fp_class_t classify(input logic [15:0] x);
        fp_class_t c;
        c.zero = (x[14:10] == '0);
        c.inf  = (x[14:10] == '1) && (x[9:0] == '0);
        c.nan  = (x[14:10] == '1) && (x[9:0] != '0);
        return c;
    endfunction

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even of a 13-bit quotient (1.10 + guard + round) plus sticky,
// packed to FP16 with overflow to Inf and underflow flush to zero.
module fp16_round_rne
    import fp16_pkg::*;
(
    input  logic              sign,
    input  logic signed [6:0] exp_in,
    input  logic [12:0]       quo,
    input  logic              sticky,
    output logic [15:0]       result
);

    logic              round_up;
    logic [11:0]       sig;
    logic signed [6:0] exp_adj;
    logic [9:0]        frac;

    always_comb begin
        round_up = quo[1] & (quo[0] | sticky | quo[2]);
        sig      = {1'b0, quo[12:2]} + {11'd0, round_up};
        exp_adj  = exp_in;
        frac     = sig[9:0];
        if (sig[11]) begin
            frac    = sig[10:1];
            exp_adj = exp_in + 7'sd1;
        end

        if (exp_adj >= 7'sd31) begin
            result = {sign, PINF[14:0]};
        end else if (exp_adj <= 7'sd0) begin
            result = {sign, 15'd0};
        end else begin
            result = {sign, exp_adj[4:0], frac};
        end
    end

endmodule

// File: rtl/fp16_divider.sv
// Iterative FP16 divider: Q = A / B, one restoring-division quotient bit per clock,
// start/done handshake, special operands resolved in a single UNPACK cycle.
module fp16_divider
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Q,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    state_t state, state_nxt;

    logic [15:0]       a_r, b_r;
    logic [10:0]       mb;
    logic [11:0]       rem;
    logic [12:0]       quo;
    logic [3:0]        cnt;
    logic signed [6:0] exp_r;

    fp_class_t         ca, cb;
    logic              sign;
    logic              special;
    logic [15:0]       spec_q;
    logic              spec_dbz;
    logic [10:0]       ma_u, mb_u;
    logic signed [6:0] ea_s, eb_s, exp_u, exp_init;
    logic [11:0]       rem_init;
    logic              ge;
    logic [11:0]       diff, rem_nxt;
    logic [12:0]       quo_nxt;
    logic [15:0]       rounded;

    always_comb begin
        ca       = classify(a_r);
        cb       = classify(b_r);
        sign     = a_r[15] ^ b_r[15];
        special  = 1'b1;
        spec_q   = QNAN;
        spec_dbz = 1'b0;
        if (ca.nan || cb.nan || (ca.zero && cb.zero) || (ca.inf && cb.inf)) begin
            spec_q = QNAN;
        end else if (cb.zero) begin
            // A is nonzero here; only a finite A flags divide-by-zero.
            spec_q   = {sign, PINF[14:0]};
            spec_dbz = !ca.inf;
        end else if (ca.inf) begin
            spec_q = {sign, PINF[14:0]};
        end else if (ca.zero || cb.inf) begin
            spec_q = {sign, 15'd0};
        end else begin
            special = 1'b0;
        end
    end

    // Pre-normalise so the first quotient bit is always the integer 1.
    always_comb begin
        ma_u  = {1'b1, a_r[9:0]};
        mb_u  = {1'b1, b_r[9:0]};
        ea_s  = {2'b00, a_r[14:10]};
        eb_s  = {2'b00, b_r[14:10]};
        exp_u = ea_s - eb_s + 7'sd15;
        if (ma_u < mb_u) begin
            rem_init = {ma_u, 1'b0};
            exp_init = exp_u - 7'sd1;
        end else begin
            rem_init = {1'b0, ma_u};
            exp_init = exp_u;
        end
    end

    always_comb begin
        ge      = (rem >= {1'b0, mb});
        diff    = ge ? (rem - {1'b0, mb}) : rem;
        rem_nxt = diff << 1;
        quo_nxt = {quo[11:0], ge};
    end

    fp16_round_rne u_round (
        .sign   (sign),
        .exp_in (exp_r),
        .quo    (quo),
        .sticky (rem != '0),
        .result (rounded)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nxt = UNPACK;
            UNPACK:  state_nxt = special ? IDLE : DIVIDE;
            DIVIDE:  if (cnt == 4'd12) state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            Q           <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            mb          <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            exp_r       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= A;
                        b_r <= B;
                    end
                end
                UNPACK: begin
                    if (special) begin
                        Q           <= spec_q;
                        div_by_zero <= spec_dbz;
                        done        <= 1'b1;
                    end else begin
                        mb    <= mb_u;
                        rem   <= rem_init;
                        exp_r <= exp_init;
                        quo   <= '0;
                        cnt   <= '0;
                    end
                end
                DIVIDE: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 4'd1;
                end
                ROUND: begin
                    Q           <= rounded;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_divider.sv
// Scoreboard bench for fp16_divider: directed and random divisions checked against
// a real-arithmetic reference, plus handshake and reset behaviour.
module tb_fp16_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A, B;
    logic [15:0] Q;
    logic        busy, done, div_by_zero;

    fp16_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .Q           (Q),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic        dbz;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic real mag(input logic [15:0] x);
        real r;
        int  e;
        r = real'(1024 + int'(x[9:0])) / 1024.0;
        e = int'(x[14:10]) - 15;
        for (int i = 0; i < e; i++) r = r * 2.0;
        for (int i = 0; i > e; i--) r = r / 2.0;
        return r;
    endfunction

    function automatic exp_t mk(input logic [15:0] q, input logic dbz, input int lat);
        exp_t r;
        r.q = q; r.dbz = dbz; r.issue = 0; r.lat = lat;
        return r;
    endfunction

    function automatic exp_t ref_div(input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        bit   sg, az, ai, an, bz, bi, bn;
        real  q, s, fr;
        int   e, ip, be;
        sg = a[15] ^ b[15];
        az = (a[14:10] == 0);
        ai = (a[14:10] == 31) && (a[9:0] == 0);
        an = (a[14:10] == 31) && (a[9:0] != 0);
        bz = (b[14:10] == 0);
        bi = (b[14:10] == 31) && (b[9:0] == 0);
        bn = (b[14:10] == 31) && (b[9:0] != 0);
        r = mk(16'h0000, 1'b0, 2);
        if (an || bn || (az && bz) || (ai && bi)) r.q = 16'h7E00;
        else if (bz) begin r.q = {sg, 15'h7C00}; r.dbz = !ai; end
        else if (ai) r.q = {sg, 15'h7C00};
        else if (az || bi) r.q = {sg, 15'h0000};
        else begin
            r.lat = 16;
            q = mag(a) / mag(b);
            e = 0;
            while (q >= 2.0) begin q = q / 2.0; e++; end
            while (q < 1.0) begin q = q * 2.0; e--; end
            s  = q * 1024.0;
            ip = $rtoi(s);
            fr = s - real'(ip);
            if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
            if (ip == 2048) begin ip = 1024; e++; end
            be = e + 15;
            if (be >= 31)     r.q = {sg, 15'h7C00};
            else if (be <= 0) r.q = {sg, 15'h0000};
            else              r.q = {sg, 5'(be), 10'(ip)};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done actual Q=%h expected no done (cycle %0d)", Q, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", {16'h0, Q}, {16'h0, e.q});
                chk("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.dbz});
                chk("latency", cyc - e.issue, e.lat);
                chk("busy_at_done", {31'h0, busy}, 32'h0);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy && sb.size() == 0) return;
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL done_timeout actual pending=%0d expected 0", sb.size());
        sb.delete();
    endtask

    task automatic issue_exp(input logic [15:0] a, input logic [15:0] b, input exp_t e);
        wait_idle();
        A = a; B = b; start = 1'b1;
        e.issue = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", {31'h0, busy}, 32'h1);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        issue_exp(a, b, ref_div(a, b));
    endtask

    function automatic logic [15:0] rand_op();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 6)       return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
        else if (r == 6) return {1'($urandom), 5'd0, 10'($urandom_range(0, 3))};
        else if (r == 7) return {1'($urandom), 5'd31, 10'($urandom_range(0, 1))};
        else             return 16'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        bit  seen;
        rst = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("reset_Q", {16'h0, Q}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_dbz", {31'h0, div_by_zero}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        issue_exp(16'h4200, 16'h3E00, mk(16'h4000, 1'b0, 16));
        issue_exp(16'h3C00, 16'h4200, mk(16'h3555, 1'b0, 16));
        issue_exp(16'hC600, 16'h4000, mk(16'hC200, 1'b0, 16));
        issue_exp(16'h3C00, 16'h0000, mk(16'h7C00, 1'b1, 2));
        issue_exp(16'h0000, 16'h0000, mk(16'h7E00, 1'b0, 2));
        issue_exp(16'h7BFF, 16'h3800, mk(16'h7C00, 1'b0, 16));
        issue_exp(16'h0400, 16'h4000, mk(16'h0000, 1'b0, 16));
        issue_exp(16'hFC00, 16'h0000, mk(16'hFC00, 1'b0, 2));
        issue_exp(16'h7C00, 16'h7C00, mk(16'h7E00, 1'b0, 2));
        issue_exp(16'h3C00, 16'hFC00, mk(16'h8000, 1'b0, 2));
        issue_exp(16'h3C01, 16'h7E01, mk(16'h7E00, 1'b0, 2));

        // start pulses mid-operation are ignored
        issue(16'h4500, 16'h4100);
        t0 = sb[0].issue;
        while (cyc < t0 + 3) @(negedge clk);
        A = 16'h3C00; B = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);

        // start held high through done launches a second division
        wait_idle();
        A = 16'h3C00; B = 16'h4200; start = 1'b1;
        sb.push_back('{16'h3555, 1'b0, cyc, 16});
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        chk("held_start_first_done", {31'h0, seen}, 32'h1);
        A = 16'hC600; B = 16'h4000;
        sb.push_back('{16'hC200, 1'b0, cyc, 16});
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset at DIVIDE edge 7 aborts without done
        issue(16'h4200, 16'h3E00);
        t0 = sb[0].issue;
        while (cyc < t0 + 7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sb.delete();
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_Q", {16'h0, Q}, 32'h0);
        rst = 1'b1;
        repeat (25) @(negedge clk);

        for (int n = 0; n < 300; n++) issue(rand_op(), rand_op());
        wait_idle();
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
